pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. Takes the hazard, redirect and multi-cycle-EX events raised by the detection logic. Drives every pipeline-register write-enable and flush from one prioritised FSM. Adds a stall watchdog that flags a pipeline stuck in stall.

## Interface
- REDIRECT_BUBBLES, 1, extra cycles IF_ID_Flush stays high after a taken redirect (0..7)
- MAX_STALL_CYCLES, 64, consecutive stalled cycles that trip the watchdog (1..255)
- Clk  input  1  clock; all state updates on rising edge
- Reset_n  input  1  asynchronous active-low reset
- LoadUseHazard  input  1  level; load in EX feeds instruction in ID
- ID_Jump  input  1  level; J/JAL/JR decoded in ID
- MEM_BranchTaken  input  1  level; branch in MEM resolved taken
- EX_MultiStart  input  1  one-cycle pulse; multi-cycle mul/div entered EX
- EX_MultiDone  input  1  one-cycle pulse; mul/div result valid
- PC_Write  output  1  PC register enable
- IF_ID_Write  output  1  IF/ID register enable
- ID_EX_Write  output  1  ID/EX register enable
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  output  1 each  insert bubble into that register
- EX_MultiAbort  output  1  one-cycle pulse; cancel in-flight mul/div
- StallTimeout  output  1  sticky watchdog error

## Operation
- States: RUN, FLUSH, EX_WAIT. Outputs combinational from state and inputs; state, counters and StallTimeout registered.
- Priority per cycle: MEM_BranchTaken > EX_WAIT/EX_MultiStart > LoadUseHazard > ID_Jump.
- Default output in RUN with no event: all writes 1, all flushes 0.
- Branch, in any state: all three flushes 1; PC_Write=1 (loads target).
  - In EX_WAIT, or with EX_MultiStart in the same cycle: also pulse EX_MultiAbort.
  - Next state: FLUSH with bubble counter = REDIRECT_BUBBLES. If the parameter is 0, next state is RUN.
- FLUSH: IF_ID_Flush=1, writes 1. Counter decrements each cycle; at 1, return to RUN. LoadUseHazard, ID_Jump and EX_MultiStart are ignored.
- EX_MultiStart in RUN: enter EX_WAIT. The same cycle already stalls.
- EX_WAIT: PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Flush=1.
  - On EX_MultiDone: writes 1, EX_MEM_Flush=0 in that cycle; next state RUN.
  - Start and Done in the same cycle: Done is treated as a completed one-cycle op; no EX_WAIT.
- LoadUseHazard in RUN: PC_Write=IF_ID_Write=0, ID_EX_Flush=1 for as long as the level is high.
- ID_Jump in RUN, no stall: IF_ID_Flush=1. With a concurrent load-use stall, the jump is deferred; IF_ID_Flush stays 0.
- Watchdog: 8-bit saturating counter of consecutive cycles with PC_Write=0; cleared when PC_Write=1. When it reaches MAX_STALL_CYCLES, StallTimeout sets and stays set until reset.

## Timing
- Reset_n low: state RUN, counters 0, StallTimeout=0, EX_MultiAbort=0.
  - Outputs forced: PC_Write=IF_ID_Write=ID_EX_Write=0, all flushes=1.
- First edge after release: normal RUN outputs.
- Reset mid-EX_WAIT or mid-FLUSH: state returns to RUN asynchronously; no EX_MultiAbort pulse.
- Zero-cycle response: every stall/flush is visible in the same cycle the input event is sampled.
- Redirect cost: 3 bubbles in the event cycle plus REDIRECT_BUBBLES.
- Mul/div stall length: cycles from EX_MultiStart to EX_MultiDone inclusive of Start, exclusive of Done.
- EX_MultiDone while not in EX_WAIT (and no Start): ignored.

## Configuration
- STALL_PERF_EN defined: adds two outputs.
  - StallCycles [31:0]: wrapping count of cycles with PC_Write=0.
  - RedirectCount [15:0]: wrapping count of MEM_BranchTaken cycles.
  - Both zero on reset.
- Undefined: neither port nor counters exist. All other behaviour is identical.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - state enum (RUN, FLUSH, EX_WAIT);
  - bubble-counter width constant (3);
  - watchdog width constant (8).
- One sub-module, stall_watchdog: saturating counter plus sticky flag, parameterised by MAX_STALL_CYCLES.

## Test plan
- Reset held 3 cycles, then released -> during reset all writes 0 and flushes 1. After the first edge: writes 1, flushes 0, StallTimeout 0.
- LoadUseHazard high 2 cycles -> PC_Write=IF_ID_Write=0 and ID_EX_Flush=1 for exactly 2 cycles, then normal.
- EX_MultiStart at cycle 10, EX_MultiDone at cycle 15 -> writes 0 and EX_MEM_Flush=1 for cycles 10–14. Cycle 15: writes 1.
- MEM_BranchTaken in cycle 12 of the previous scenario, REDIRECT_BUBBLES=2 -> EX_MultiAbort pulses in cycle 12 with all flushes 1. IF_ID_Flush stays 1 in cycles 13–14; RUN at cycle 15.
- LoadUseHazard and ID_Jump together for 1 cycle -> stall only, IF_ID_Flush=0. Next cycle with Jump only -> IF_ID_Flush=1.
- MAX_STALL_CYCLES=4, LoadUseHazard held 6 cycles -> StallTimeout rises at the edge ending the 4th stalled cycle. It stays 1 after the hazard drops, until Reset_n is asserted.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the controller state encoding, the bubble and watchdog counter
// widths, and a saturating-increment helper for the watchdog counter.
package pipeline_ctrl_pkg;

    // Controller states: normal flow, post-redirect bubbles, multi-cycle EX wait
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        EX_WAIT = 2'd2
    } ctrl_state_t;

    // Width of the redirect bubble counter (REDIRECT_BUBBLES range 0..7)
    localparam int BUBBLE_CNT_W = 3;

    // Width of the consecutive-stall watchdog counter (limit range 1..255)
    localparam int WATCHDOG_W = 8;

    // Increment that holds at all-ones instead of wrapping back to zero
    function automatic logic [WATCHDOG_W-1:0] sat_inc(input logic [WATCHDOG_W-1:0] value);
        logic [WATCHDOG_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + WATCHDOG_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: counts consecutive cycles in which the PC is held and
// raises a sticky timeout flag once the run length reaches the limit.
// The flag is only cleared by reset so software can see that it happened.
module stall_watchdog
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_STALL_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic timeout
);

    localparam logic [WATCHDOG_W-1:0] LIMIT = WATCHDOG_W'(MAX_STALL_CYCLES);

    logic [WATCHDOG_W-1:0] count;
    logic [WATCHDOG_W-1:0] count_next;

    // Next run length: grows while stalled, restarts as soon as the PC moves
    always_comb begin
        count_next = '0;
        if (stall) begin
            count_next = sat_inc(count);
        end
    end

    // Run-length register and sticky flag; the flag sets on the edge that
    // closes the stalled cycle bringing the run length up to the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            count <= count_next;
            if (stall && (count_next >= LIMIT)) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Turns hazard, redirect and multi-cycle EX events into pipeline-register
// write enables and flushes from one prioritised FSM, and watches for a
// pipeline stuck in stall.
// Optional build macro STALL_PERF_EN adds StallCycles and RedirectCount
// performance counters; without it those ports do not exist.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MAX_STALL_CYCLES = 64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        LoadUseHazard,
    input  logic        ID_Jump,
    input  logic        MEM_BranchTaken,
    input  logic        EX_MultiStart,
    input  logic        EX_MultiDone,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Flush,
    output logic        EX_MultiAbort,
`ifdef STALL_PERF_EN
    output logic [31:0] StallCycles,
    output logic [15:0] RedirectCount,
`endif
    output logic        StallTimeout
);

    localparam logic [BUBBLE_CNT_W-1:0] BUBBLES = BUBBLE_CNT_W'(REDIRECT_BUBBLES);

    ctrl_state_t               state;
    ctrl_state_t               state_next;
    logic [BUBBLE_CNT_W-1:0]   bubble_cnt;
    logic [BUBBLE_CNT_W-1:0]   bubble_next;

    // State and bubble counter; reset drops straight back to RUN with no abort
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= RUN;
            bubble_cnt <= '0;
        end else begin
            state      <= state_next;
            bubble_cnt <= bubble_next;
        end
    end

    // Prioritised next-state and output decode:
    // taken branch > multi-cycle EX > load-use stall > jump redirect
    always_comb begin
        state_next    = state;
        bubble_next   = bubble_cnt;
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Flush  = 1'b0;
        EX_MultiAbort = 1'b0;

        if (!Reset_n) begin
            // Hold every register and keep bubbles flowing while in reset
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            state_next   = RUN;
            bubble_next  = '0;
        end else if (MEM_BranchTaken) begin
            // Redirect wins in any state: squash the three younger stages,
            // let the PC load the target, and kill any mul/div in flight
            IF_ID_Flush   = 1'b1;
            ID_EX_Flush   = 1'b1;
            EX_MEM_Flush  = 1'b1;
            EX_MultiAbort = (state == EX_WAIT) || EX_MultiStart;
            bubble_next   = BUBBLES;
            if (BUBBLES == '0) begin
                state_next = RUN;
            end else begin
                state_next = FLUSH;
            end
        end else begin
            case (state)
                FLUSH: begin
                    // Extra redirect bubbles; younger events are ignored here
                    IF_ID_Flush = 1'b1;
                    if (bubble_cnt <= BUBBLE_CNT_W'(1)) begin
                        bubble_next = '0;
                        state_next  = RUN;
                    end else begin
                        bubble_next = bubble_cnt - BUBBLE_CNT_W'(1);
                    end
                end

                EX_WAIT: begin
                    // Freeze the front end until the mul/div result is valid
                    if (EX_MultiDone) begin
                        state_next = RUN;
                    end else begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                    end
                end

                default: begin
                    if (EX_MultiStart && !EX_MultiDone) begin
                        // Mul/div entering EX stalls in this very cycle
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        state_next   = EX_WAIT;
                    end else if (LoadUseHazard) begin
                        // Hold PC and IF/ID, bubble into ID/EX; a concurrent
                        // jump is deferred until the stall clears
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end else if (ID_Jump) begin
                        // Squash the wrong-path fetch behind the jump
                        IF_ID_Flush = 1'b1;
                    end
                end
            endcase
        end
    end

    stall_watchdog #(
        .MAX_STALL_CYCLES(MAX_STALL_CYCLES)
    ) u_watchdog (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .stall  (!PC_Write),
        .timeout(StallTimeout)
    );

`ifdef STALL_PERF_EN
    // Free-running wrapping counters of stalled cycles and taken redirects
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            StallCycles   <= '0;
            RedirectCount <= '0;
        end else begin
            if (!PC_Write) begin
                StallCycles <= StallCycles + 32'd1;
            end
            if (MEM_BranchTaken) begin
                RedirectCount <= RedirectCount + 16'd1;
            end
        end
    end
`endif

endmodule
